jpeg_stream_arb: RTL and testbench
==================================

Name: jpeg_stream_arb

Overview:
- Shares one jpeg_core decoder between two independent 32-bit JPEG file input streams.
- Grants the decoder input to one source for a whole file, from first beat to the `last` beat.
- Before re-arbitrating, waits for the core to drain, judged by idle_i held high.
- Tags the decoder pixel output with the owning source and reports per-source frame completion and drain timeouts.
- Sits between system DMA/stream sources and jpeg_core inport_*.

Parameters:
- IDLE_HOLD, 16: consecutive cycles core_idle_i must be high to declare the frame drained (1..255).
- DRAIN_TIMEOUT, 0: max cycles in DRAIN before forced release; 0 disables the timeout (32-bit compare).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- src0_valid_i / src1_valid_i  in  1  source beat valid
- src0_data_i / src1_data_i  in  32  source data
- src0_strb_i / src1_strb_i  in  4  byte strobes
- src0_last_i / src1_last_i  in  1  final beat of the JPEG file
- src0_accept_o / src1_accept_o  out  1  beat accepted
- core_valid_o  out  1  to jpeg_core inport_valid_i
- core_data_o  out  32  to inport_data_i
- core_strb_o  out  4  to inport_strb_i
- core_last_o  out  1  to inport_last_i
- core_accept_i  in  1  from inport_accept_o
- core_idle_i  in  1  from jpeg_core idle_o
- owner_o  out  1  source currently owning the decoder; valid while busy_o
- busy_o  out  1  STREAM or DRAIN state
- frame_done_o  out  1  one-cycle pulse when a frame fully drains
- frame_done_src_o  out  1  source of the completed frame; qualified by frame_done_o
- timeout_o  out  1  one-cycle pulse on DRAIN timeout
- frame_cnt0_o / frame_cnt1_o  out  16  completed frames per source; wraps 0xFFFF->0

Behaviour:
- Reset, asynchronous and immediate:
  - state=ARB, owner=0, last_served=1 so src0 wins the first tie.
  - All counters 0.
  - All outputs 0, including both accepts and core_valid_o.
- ARB state:
  - No accepts are given and core_valid_o=0.
  - If exactly one srcN_valid_i is high, grant that source.
  - If both are high, grant the source other than last_served.
  - The grant is registered: STREAM starts next cycle, so the first beat forwards at least 1 cycle after valid rises.
  - Set last_served=owner.
- STREAM state:
  - Combinational forwarding: core_valid_o=srcN_valid_i; data/strb/last follow the owner; srcN_accept_o=core_accept_i for the owner only; the non-owner accept is 0.
  - A beat transfers when valid&accept are both high.
  - A transferred beat with last=1 moves the state to DRAIN next cycle and clears hold_cnt and drain_cnt.
  - No beat is dropped or duplicated; the non-owner source stalls indefinitely.
- DRAIN state:
  - core_valid_o=0 and both accepts=0.
  - hold_cnt increments while core_idle_i=1 and clears to 0 on any cycle with core_idle_i=0.
  - drain_cnt increments every cycle.
  - When hold_cnt reaches IDLE_HOLD-1 with core_idle_i=1, go to ARB next cycle.
    - Pulse frame_done_o with frame_done_src_o=owner.
    - Increment frame_cntN_o for the owner.
  - Timeout: when DRAIN_TIMEOUT!=0 and drain_cnt reaches DRAIN_TIMEOUT-1, go to ARB next cycle and pulse timeout_o. No frame_done_o pulse and no counter increment.
  - If both the hold condition and the timeout occur in the same cycle, completion wins: frame_done_o pulses, timeout_o does not.
- owner_o / busy_o:
  - owner_o holds through STREAM and DRAIN, so it tags every pixel of the frame.
  - busy_o=1 in STREAM and DRAIN.
- Back-to-back: in the ARB cycle after a drain, the round-robin picks the other source if it is valid.
- Minimum per-frame overhead: 1 ARB cycle + IDLE_HOLD drain cycles.
- Reset mid-STREAM or mid-DRAIN:
  - Returns to ARB with no pulse; counters clear.
  - Core recovery is the integrator's responsibility: rst_i is shared with the core.

Decomposition:
- jpeg_arb_pkg holds:
  - state encoding ARB=2'd0, STREAM=2'd1, DRAIN=2'd2;
  - the source-index width;
  - the default IDLE_HOLD constant.
- One natural sub-module, jpeg_rr_arb2: a two-requester round-robin pick with a last_served register.
- The data mux and the DRAIN counters stay in the top module.

Test Plan:
- Single frame, basic forwarding:
  - Stimulus: src0 sends 4 beats (last on the 4th); core_accept_i=1; core_idle_i low for 50 cycles, then high.
  - Required: all 4 beats forwarded unmodified; src1_accept_o=0 throughout; frame_done_o pulses exactly IDLE_HOLD cycles after idle rises, with frame_done_src_o=0; frame_cnt0_o=1.
- Simultaneous request, round-robin:
  - Stimulus: both sources valid with 2-beat frames.
  - Required: src0 served first, then src1, then src0; owner_o sequence is 0,1,0; frame_cnt0_o=2 and frame_cnt1_o=1.
- Idle glitch during drain:
  - Stimulus: in DRAIN, core_idle_i is high 10 cycles, low 1 cycle, then high.
  - Required: done pulses 16 cycles after the second rise, not the first.
- Timeout:
  - Stimulus: DRAIN_TIMEOUT=100; core_idle_i stuck low.
  - Required: timeout_o pulses once, 100 cycles after DRAIN entry; no frame_done_o; counters unchanged; next frame is accepted.
- Backpressure:
  - Stimulus: core_accept_i toggles 1,0,0,1 while src0 holds its beat.
  - Required: beat transfers only on accept cycles; no duplication.
- Reset mid-STREAM:
  - Stimulus: assert rst_i asynchronously between clock edges.
  - Required: accepts and core_valid_o go 0 immediately; state ARB; frame_cnt0_o=0.

Source files
------------

// File: rtl/jpeg_arb_pkg.sv
// Shared types and constants for the two-source JPEG stream arbiter.
// The state encoding is fixed so the state can be read directly in a debugger.
package jpeg_arb_pkg;

  localparam int SRC_W         = 1;
  localparam int DEF_IDLE_HOLD = 16;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } arb_state_t;

  typedef logic [SRC_W-1:0] src_idx_t;

endpackage

// File: rtl/jpeg_rr_arb2.sv
// Two-requester round-robin pick. On a tie the requester that was not served
// last wins; the last-served memory updates only when the grant is taken.
module jpeg_rr_arb2
  import jpeg_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic       o_grant_valid,
  output src_idx_t   o_grant
);

  logic r_last_served;

  always_comb begin
    o_grant_valid = |i_req;
    if (i_req == 2'b11) begin
      o_grant = ~r_last_served;
    end else begin
      o_grant = i_req[1];
    end
  end

  // Reset to 1 so that source 0 wins the very first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_served <= 1'b1;
    end else if (i_take && o_grant_valid) begin
      r_last_served <= o_grant;
    end
  end

endmodule

// File: rtl/jpeg_stream_arb.sv
// Shares one jpeg_core input port between two JPEG file streams: a whole file
// is forwarded from one source, then the core is drained before re-arbitrating.
module jpeg_stream_arb
  import jpeg_arb_pkg::*;
#(
  parameter int IDLE_HOLD     = DEF_IDLE_HOLD,
  parameter int DRAIN_TIMEOUT = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        src0_valid_i,
  input  logic [31:0] src0_data_i,
  input  logic [3:0]  src0_strb_i,
  input  logic        src0_last_i,
  output logic        src0_accept_o,
  input  logic        src1_valid_i,
  input  logic [31:0] src1_data_i,
  input  logic [3:0]  src1_strb_i,
  input  logic        src1_last_i,
  output logic        src1_accept_o,
  output logic        core_valid_o,
  output logic [31:0] core_data_o,
  output logic [3:0]  core_strb_o,
  output logic        core_last_o,
  input  logic        core_accept_i,
  input  logic        core_idle_i,
  output logic        owner_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        frame_done_src_o,
  output logic        timeout_o,
  output logic [15:0] frame_cnt0_o,
  output logic [15:0] frame_cnt1_o
);

  localparam logic [7:0]  HOLD_LAST = 8'(IDLE_HOLD - 1);
  localparam logic [31:0] TO_LAST   = 32'(DRAIN_TIMEOUT - 1);
  localparam logic        TO_EN     = (DRAIN_TIMEOUT != 0);

  arb_state_t  r_state, w_state_next;
  src_idx_t    r_owner, w_owner_next;
  logic [7:0]  r_hold_cnt, w_hold_next;
  logic [31:0] r_drain_cnt, w_drain_next;
  logic        r_frame_done, r_timeout;
  src_idx_t    r_done_src;
  logic [15:0] r_cnt0, r_cnt1;

  logic        w_grant_valid;
  src_idx_t    w_grant;
  logic        w_streaming;
  logic        w_own_valid, w_own_last;
  logic [31:0] w_own_data;
  logic [3:0]  w_own_strb;
  logic        w_last_beat;
  logic        w_hold_hit, w_to_hit;

  jpeg_rr_arb2 u_rr (
    .i_clk        (clk_i),
    .i_rst        (rst_i),
    .i_req        ({src1_valid_i, src0_valid_i}),
    .i_take       (r_state == ST_ARB),
    .o_grant_valid(w_grant_valid),
    .o_grant      (w_grant)
  );

  assign w_streaming = (r_state == ST_STREAM);
  assign w_own_valid = r_owner[0] ? src1_valid_i : src0_valid_i;
  assign w_own_data  = r_owner[0] ? src1_data_i  : src0_data_i;
  assign w_own_strb  = r_owner[0] ? src1_strb_i  : src0_strb_i;
  assign w_own_last  = r_owner[0] ? src1_last_i  : src0_last_i;

  // Forwarding is purely combinational so a beat costs no extra latency.
  assign core_valid_o  = w_streaming & w_own_valid;
  assign core_data_o   = w_streaming ? w_own_data : 32'd0;
  assign core_strb_o   = w_streaming ? w_own_strb : 4'd0;
  assign core_last_o   = w_streaming & w_own_last;
  assign src0_accept_o = w_streaming & ~r_owner[0] & core_accept_i;
  assign src1_accept_o = w_streaming &  r_owner[0] & core_accept_i;

  assign w_last_beat = core_valid_o & core_accept_i & w_own_last;
  assign w_hold_hit  = (r_state == ST_DRAIN) && core_idle_i && (r_hold_cnt == HOLD_LAST);
  // Completion takes priority when both conditions land on the same cycle.
  assign w_to_hit    = (r_state == ST_DRAIN) && TO_EN && (r_drain_cnt == TO_LAST) && !w_hold_hit;

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_hold_next  = r_hold_cnt;
    w_drain_next = r_drain_cnt;
    case (r_state)
      ST_ARB: begin
        if (w_grant_valid) begin
          w_state_next = ST_STREAM;
          w_owner_next = w_grant;
        end
      end
      ST_STREAM: begin
        if (w_last_beat) begin
          w_state_next = ST_DRAIN;
          w_hold_next  = 8'd0;
          w_drain_next = 32'd0;
        end
      end
      ST_DRAIN: begin
        w_hold_next  = core_idle_i ? r_hold_cnt + 8'd1 : 8'd0;
        w_drain_next = r_drain_cnt + 32'd1;
        if (w_hold_hit || w_to_hit) begin
          w_state_next = ST_ARB;
        end
      end
      default: w_state_next = ST_ARB;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_ARB;
      r_owner      <= '0;
      r_hold_cnt   <= 8'd0;
      r_drain_cnt  <= 32'd0;
      r_frame_done <= 1'b0;
      r_done_src   <= '0;
      r_timeout    <= 1'b0;
      r_cnt0       <= 16'd0;
      r_cnt1       <= 16'd0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_hold_cnt   <= w_hold_next;
      r_drain_cnt  <= w_drain_next;
      r_frame_done <= w_hold_hit;
      r_done_src   <= w_hold_hit ? r_owner : '0;
      r_timeout    <= w_to_hit;
      if (w_hold_hit && !r_owner[0]) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_hold_hit &&  r_owner[0]) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign owner_o          = r_owner[0];
  assign busy_o           = (r_state != ST_ARB);
  assign frame_done_o     = r_frame_done;
  assign frame_done_src_o = r_done_src[0];
  assign timeout_o        = r_timeout;
  assign frame_cnt0_o     = r_cnt0;
  assign frame_cnt1_o     = r_cnt1;

endmodule

// File: tb/tb_jpeg_stream_arb.sv
// Self-checking bench for jpeg_stream_arb: a cycle model of the arbitration
// rules checked every cycle, plus directed scenarios with literal expectations.
module tb_jpeg_stream_arb;

  localparam int HOLD = 16;
  localparam int TO   = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0, v1, l0, l1;
  logic [31:0] d0, d1;
  logic [3:0]  s0, s1;
  logic        acc, idle;

  logic        acc0_o, acc1_o, cv_o, cl_o, own_o, busy_o, done_o, dsrc_o, to_o;
  logic [31:0] cd_o;
  logic [3:0]  cs_o;
  logic [15:0] cnt0_o, cnt1_o;

  always #5 clk = ~clk;

  jpeg_stream_arb #(.IDLE_HOLD(HOLD), .DRAIN_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .src0_valid_i(v0), .src0_data_i(d0), .src0_strb_i(s0), .src0_last_i(l0), .src0_accept_o(acc0_o),
    .src1_valid_i(v1), .src1_data_i(d1), .src1_strb_i(s1), .src1_last_i(l1), .src1_accept_o(acc1_o),
    .core_valid_o(cv_o), .core_data_o(cd_o), .core_strb_o(cs_o), .core_last_o(cl_o),
    .core_accept_i(acc), .core_idle_i(idle),
    .owner_o(own_o), .busy_o(busy_o), .frame_done_o(done_o), .frame_done_src_o(dsrc_o),
    .timeout_o(to_o), .frame_cnt0_o(cnt0_o), .frame_cnt1_o(cnt1_o)
  );

  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } beat_t;
  typedef struct packed { logic src; logic [31:0] data; logic [3:0] strb; logic last; int cyc; } rx_t;

  beat_t q0[$], q1[$];
  rx_t   rx[$];
  int    done_srcs[$];

  int n_run = 0, n_fail = 0, cyc = 0;
  int done_seen = 0, to_seen = 0, last_done_cyc = 0, last_to_cyc = 0, drain_entry = 0;

  // Model state: whole-frame view of who owns the core and how long it has drained.
  bit m_busy, m_drain, m_done, m_to;
  int m_own, m_last, m_run, m_age, m_dsrc, m_cnt0, m_cnt1;
  bit e_str, e_valid, e_last;
  logic [31:0] e_data;
  logic [3:0]  e_strb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void drive();
    v0 = q0.size() > 0;
    d0 = v0 ? q0[0].data : 32'd0;
    s0 = v0 ? q0[0].strb : 4'd0;
    l0 = v0 ? q0[0].last : 1'b0;
    v1 = q1.size() > 0;
    d1 = v1 ? q1[0].data : 32'd0;
    s1 = v1 ? q1[0].strb : 4'd0;
    l1 = v1 ? q1[0].last : 1'b0;
  endfunction

  function automatic void push_frame(input int src, input int n, input logic [31:0] base);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = base + 32'(k);
      b.strb = 4'hF ^ 4'(k);
      b.last = (k == n - 1);
      if (src == 0) q0.push_back(b); else q1.push_back(b);
    end
  endfunction

  // One clock: note which source beats are taken, then advance sources after the edge.
  task automatic tick();
    bit f0, f1;
    @(negedge clk);
    f0 = v0 && acc0_o;
    f1 = v1 && acc1_o;
    @(posedge clk);
    #2;
    if (f0 && q0.size() > 0) void'(q0.pop_front());
    if (f1 && q1.size() > 0) void'(q1.pop_front());
    drive();
  endtask

  task automatic wait_done(input string name, input int budget);
    int start = done_seen;
    int i = 0;
    while (done_seen == start && i < budget) begin tick(); i++; end
    chk(name, 32'(done_seen - start), 32'd1);
  endtask

  task automatic wait_to(input string name, input int budget);
    int start = to_seen;
    int i = 0;
    while (to_seen == start && i < budget) begin tick(); i++; end
    chk(name, 32'(to_seen - start), 32'd1);
  endtask

  task automatic chk_rx(input string name, input int idx, input int src, input logic [31:0] data);
    if (idx >= rx.size()) begin
      chk(name, 32'(rx.size()), 32'(idx + 1));
    end else begin
      chk({name, "_src"}, 32'(rx[idx].src), 32'(src));
      chk({name, "_data"}, rx[idx].data, data);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_core_valid", 32'(cv_o), 32'd0);
      chk("rst_acc0", 32'(acc0_o), 32'd0);
      chk("rst_acc1", 32'(acc1_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_owner", 32'(own_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_timeout", 32'(to_o), 32'd0);
      chk("rst_cnt0", 32'(cnt0_o), 32'd0);
      chk("rst_cnt1", 32'(cnt1_o), 32'd0);
      m_busy = 0; m_drain = 0; m_done = 0; m_to = 0;
      m_own = 0; m_last = 1; m_run = 0; m_age = 0; m_dsrc = 0; m_cnt0 = 0; m_cnt1 = 0;
    end else begin
      e_str   = m_busy && !m_drain;
      e_valid = e_str && ((m_own == 1) ? v1 : v0);
      e_data  = e_str ? ((m_own == 1) ? d1 : d0) : 32'd0;
      e_strb  = e_str ? ((m_own == 1) ? s1 : s0) : 4'd0;
      e_last  = e_str && ((m_own == 1) ? l1 : l0);
      chk("core_valid", 32'(cv_o), 32'(e_valid));
      chk("core_data", cd_o, e_data);
      chk("core_strb", 32'(cs_o), 32'(e_strb));
      chk("core_last", 32'(cl_o), 32'(e_last));
      chk("src0_accept", 32'(acc0_o), 32'(e_str && m_own == 0 && acc));
      chk("src1_accept", 32'(acc1_o), 32'(e_str && m_own == 1 && acc));
      chk("busy", 32'(busy_o), 32'(m_busy));
      chk("owner", 32'(own_o), 32'(m_own));
      chk("frame_done", 32'(done_o), 32'(m_done));
      if (m_done) chk("frame_done_src", 32'(dsrc_o), 32'(m_dsrc));
      chk("timeout", 32'(to_o), 32'(m_to));
      chk("frame_cnt0", 32'(cnt0_o), 32'(m_cnt0));
      chk("frame_cnt1", 32'(cnt1_o), 32'(m_cnt1));

      if (done_o) begin
        done_seen++;
        last_done_cyc = cyc;
        done_srcs.push_back(int'(dsrc_o));
        $display("[TB] frame done src=%0d cycle=%0d cnt0=%0d cnt1=%0d", dsrc_o, cyc, cnt0_o, cnt1_o);
      end
      if (to_o) begin
        to_seen++;
        last_to_cyc = cyc;
        $display("[TB] drain timeout cycle=%0d", cyc);
      end
      if (cv_o && acc) begin
        rx.push_back('{src: own_o, data: cd_o, strb: cs_o, last: cl_o, cyc: cyc});
        if (cl_o) drain_entry = cyc + 1;
      end

      m_done = 0;
      m_to   = 0;
      if (!m_busy) begin
        if (v0 || v1) begin
          m_own   = (v0 && v1) ? 1 - m_last : (v1 ? 1 : 0);
          m_last  = m_own;
          m_busy  = 1;
          m_drain = 0;
        end
      end else if (!m_drain) begin
        if (e_valid && acc && e_last) begin
          m_drain = 1; m_run = 0; m_age = 0;
        end
      end else begin
        m_run = idle ? m_run + 1 : 0;
        m_age++;
        if (idle && m_run == HOLD) begin
          m_done = 1; m_dsrc = m_own; m_busy = 0;
          if (m_own == 0) m_cnt0 = (m_cnt0 + 1) % 65536;
          else            m_cnt1 = (m_cnt1 + 1) % 65536;
        end else if (TO != 0 && m_age == TO) begin
          m_to = 1; m_busy = 0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  int rise, start, i;
  int pat[7] = '{1, 0, 0, 1, 1, 1, 1};

  initial begin
    acc = 1'b1; idle = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_owner", 32'(own_o), 32'd0);
    chk("reset_cnt0", 32'(cnt0_o), 32'd0);

    // Single frame: 4 beats from src0, idle held low for 50 cycles.
    idle = 1'b0; rx.delete();
    push_frame(0, 4, 32'hA000_0000);
    drive();
    start = done_seen;
    repeat (50) tick();
    chk("t1_busy_in_drain", 32'(busy_o), 32'd1);
    chk("t1_no_early_done", 32'(done_seen - start), 32'd0);
    idle = 1'b1; rise = cyc;
    wait_done("t1_done", 40);
    chk("t1_done_latency", 32'(last_done_cyc - rise), 32'd16);
    chk("t1_done_src", 32'(done_srcs[done_srcs.size() - 1]), 32'd0);
    chk("t1_rx_count", 32'(rx.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk_rx("t1_beat", k, 0, 32'hA000_0000 + 32'(k));
    chk("t1_cnt0", 32'(cnt0_o), 32'd1);

    // Backpressure: accept pattern 1,0,0,1,... on a 3-beat src0 frame.
    acc = 1'b0; rx.delete();
    push_frame(0, 3, 32'hB000_0000);
    drive();
    i = 0;
    while (!busy_o && i < 5) begin tick(); i++; end
    chk("t5_granted", 32'(busy_o), 32'd1);
    foreach (pat[k]) begin acc = pat[k][0]; tick(); end
    chk("t5_rx_count", 32'(rx.size()), 32'd3);
    for (int k = 0; k < 3; k++) chk_rx("t5_beat", k, 0, 32'hB000_0000 + 32'(k));
    if (rx.size() == 3) begin
      chk("t5_gap01", 32'(rx[1].cyc - rx[0].cyc), 32'd3);
      chk("t5_gap12", 32'(rx[2].cyc - rx[1].cyc), 32'd1);
    end
    wait_done("t5_done", 40);
    chk("t5_cnt0", 32'(cnt0_o), 32'd2);

    // Asynchronous reset in the middle of a src0 frame.
    acc = 1'b1; rx.delete();
    push_frame(0, 4, 32'hC000_0000);
    drive();
    i = 0;
    while (rx.size() < 2 && i < 10) begin tick(); i++; end
    chk("t6_pre_valid", 32'(cv_o), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_valid_now", 32'(cv_o), 32'd0);
    chk("t6_acc0_now", 32'(acc0_o), 32'd0);
    chk("t6_busy_now", 32'(busy_o), 32'd0);
    chk("t6_cnt0_now", 32'(cnt0_o), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    q0.delete(); q1.delete();
    drive();
    chk("t6_cnt0_after", 32'(cnt0_o), 32'd0);

    // Round-robin: both sources request at once; src0 has two frames queued.
    idle = 1'b1; rx.delete(); done_srcs.delete();
    push_frame(0, 2, 32'h0000_1000);
    push_frame(0, 2, 32'h0000_2000);
    push_frame(1, 2, 32'h1111_0000);
    drive();
    start = done_seen;
    i = 0;
    while (done_seen - start < 3 && i < 200) begin tick(); i++; end
    chk("t2_frames", 32'(done_seen - start), 32'd3);
    chk("t2_rx_count", 32'(rx.size()), 32'd6);
    chk_rx("t2_b0", 0, 0, 32'h0000_1000);
    chk_rx("t2_b1", 1, 0, 32'h0000_1001);
    chk_rx("t2_b2", 2, 1, 32'h1111_0000);
    chk_rx("t2_b3", 3, 1, 32'h1111_0001);
    chk_rx("t2_b4", 4, 0, 32'h0000_2000);
    chk_rx("t2_b5", 5, 0, 32'h0000_2001);
    if (done_srcs.size() == 3) begin
      chk("t2_order0", 32'(done_srcs[0]), 32'd0);
      chk("t2_order1", 32'(done_srcs[1]), 32'd1);
      chk("t2_order2", 32'(done_srcs[2]), 32'd0);
    end
    chk("t2_cnt0", 32'(cnt0_o), 32'd2);
    chk("t2_cnt1", 32'(cnt1_o), 32'd1);

    // Idle glitch: 10 idle cycles, one busy cycle, then idle again.
    idle = 1'b0; rx.delete();
    push_frame(1, 2, 32'hE000_0000);
    drive();
    i = 0;
    while (rx.size() < 2 && i < 10) begin tick(); i++; end
    start = done_seen;
    idle = 1'b1; repeat (10) tick();
    idle = 1'b0; tick();
    chk("t3_no_early_done", 32'(done_seen - start), 32'd0);
    idle = 1'b1; rise = cyc;
    wait_done("t3_done", 40);
    chk("t3_done_latency", 32'(last_done_cyc - rise), 32'd16);
    chk("t3_done_src", 32'(done_srcs[done_srcs.size() - 1]), 32'd1);
    chk("t3_cnt1", 32'(cnt1_o), 32'd2);

    // Timeout: idle stuck low after a src0 frame.
    idle = 1'b0; rx.delete();
    push_frame(0, 2, 32'hF000_0000);
    drive();
    i = 0;
    while (rx.size() < 2 && i < 10) begin tick(); i++; end
    start = done_seen;
    wait_to("t4_timeout", 150);
    chk("t4_timeout_latency", 32'(last_to_cyc - drain_entry), 32'd100);
    chk("t4_no_done", 32'(done_seen - start), 32'd0);
    chk("t4_cnt0", 32'(cnt0_o), 32'd2);
    chk("t4_cnt1", 32'(cnt1_o), 32'd2);
    idle = 1'b1; rx.delete();
    push_frame(1, 1, 32'h5555_0000);
    drive();
    wait_done("t4_next_done", 40);
    chk_rx("t4_next_beat", 0, 1, 32'h5555_0000);
    chk("t4_next_cnt1", 32'(cnt1_o), 32'd3);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
